raw_frame_loader: RTL
=====================

# raw_frame_loader

Upstream ingest stage for the demosaic core. It accepts a raw Bayer pixel stream over a valid/ready handshake and checks line and frame framing. It writes each pixel into the raw frame memory in raster order. Once a full frame is stored, it pulses `cfaStart` to launch `CFA_2` and back-pressures the stream until the core reports `done`.

## Interface
Parameters:
- `addressBitWidth`, 17: raw memory address width.
- `rowBitWidth`, 11: row index width.
- `colBitWidth`, 11: column index width.
- `dataBitWidth`, 12: raw pixel width.

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `rowMax`  in  `rowBitWidth`: last row index (frame height minus 1). Sampled on frame start.
- `colMax`  in  `colBitWidth`: last column index. Sampled on frame start.
- `pixIn`  in  `dataBitWidth`: raw pixel.
- `pixValid`  in  1: `pixIn`, `sof` and `eol` are valid.
- `sof`  in  1: first pixel of a frame.
- `eol`  in  1: last pixel of a line.
- `pixReady`  out  1: loader accepts this cycle.
- `rawWriteAddress`  out  `addressBitWidth`: raw memory write address.
- `rawWriteData`  out  `dataBitWidth`: raw memory write data.
- `rawWriteEnable`  out  1: raw memory write strobe.
- `cfaStart`  out  1: one-cycle launch pulse to `CFA_2` `start`.
- `cfaDone`  in  1: `CFA_2` `done`.
- `busy`  out  1: high in LOAD, KICK and WAIT_CFA.
- `lineError`  out  1: sticky framing error.
- `frameCount`  out  8: count of frames handed to the core; wraps 255 to 0.

## Operation
- Accept: a pixel is accepted when `pixValid & pixReady`.
- States (one-hot):
  - IDLE:
    - `pixReady`=1.
    - An accepted pixel with `sof`=0 is discarded.
    - An accepted pixel with `sof`=1: latch `rowMax`/`colMax`, clear `lineError`, write the pixel at address 0, set col=1, row=0, go to LOAD.
  - LOAD:
    - `pixReady`=1.
    - Each accepted pixel writes at the current address; the address then increments by 1.
    - col increments, or resets to 0 with row+1 when `eol`.
    - `eol` must occur exactly when col==colMax. A mismatch in either direction sets `lineError` and goes to SYNC; that pixel is not written.
    - `sof` in LOAD restarts the frame: `lineError` is set, the pixel is written at address 0 and becomes the new first pixel (new `rowMax`/`colMax` latched).
    - Accepting pixel (rowMax, colMax) with `eol` goes to KICK.
  - SYNC:
    - `pixReady`=1; pixels are discarded until an accepted `sof`.
    - That pixel is handled exactly as the IDLE `sof` case, except `lineError` stays set until the next frame completes.
  - KICK:
    - `pixReady`=0.
    - Assert `cfaStart` for one cycle, increment `frameCount`, go to WAIT_CFA.
  - WAIT_CFA:
    - `pixReady`=0.
    - On `cfaDone` go to IDLE. `cfaDone` outside WAIT_CFA is ignored.
- Address arithmetic: a linear incrementing counter, no multiplier. Frames with (rowMax+1)*(colMax+1) > 2^`addressBitWidth` are unsupported; the address wraps modulo 2^`addressBitWidth`.
- `rowMax`/`colMax` are treated as unsigned here.

## Timing
- Write latency:
  - Pixel accepted in cycle N gives `rawWriteEnable`=1 in N+1.
  - Address and data are registered and stable for that cycle.
- `cfaStart`: asserted the cycle after the final write strobe, i.e. N+2 for last pixel N.
- `pixReady`: a registered decode of the state, with no combinational path from `pixValid`. It drops the cycle after the last pixel is accepted.
- Idle restart: after `cfaDone` is sampled in cycle M, `pixReady`=1 in M+1.
- Reset values: `pixReady`=0 during reset, 1 on the first cycle after release (IDLE). All other outputs are 0 and the counters are 0.
- Reset mid-frame: state returns to IDLE immediately. A partially written frame is abandoned and `cfaStart` is never issued for it.
- 1x1 frame (rowMax=colMax=0): a `sof`+`eol` pixel goes IDLE to KICK directly.

## Structure
- Shared package `cfa_pkg`:
  - loader state encodings (IDLE=5'b00001, LOAD, SYNC, KICK, WAIT_CFA);
  - the existing idle/greenIntrp/RBIntrp codes;
  - Bayer symbol constants;
  - default width constants.
- Sub-module `raw_position_tracker`:
  - holds the row/col/address counters and the latched maxima;
  - inputs: `advance`, `restart`, `eol`;
  - outputs: `row`, `col`, `address`, `lastPixel`, `eolMismatch`.
- The top level holds the FSM, the write register and the status counters.

## Test plan
- 4x6 frame (rowMax=3, colMax=5), `pixValid` always high -> 24 writes at addresses 0..23 with matching data; `cfaStart` 2 cycles after the last acceptance; `frameCount`=1; `pixReady`=0 until `cfaDone`.
- Random `pixValid` gaps on the same frame -> identical write sequence; no write in any cycle without a prior acceptance.
- `eol` at col 3 of row 1 (colMax=5) -> `lineError`=1, SYNC, no further writes. The next `sof` frame loads from address 0; `lineError` clears once that frame completes.
- `sof` reasserted at pixel 10 -> `lineError`=1 and address restarts at 0. The 24-pixel frame completes from the new `sof` and `frameCount` increments once.
- `cfaDone` pulse during LOAD -> ignored, loading continues. `rst` low during WAIT_CFA -> all outputs 0; `pixReady`=1 the cycle after release.
- 256 back-to-back 1x1 frames -> `frameCount` wraps to 0; each frame produces exactly one write and one `cfaStart`.

Source files
------------

// File: rtl/cfa_pkg.sv
// cfa_pkg: shared loader state codes, CFA phase codes, Bayer symbols and default widths
package cfa_pkg;
  localparam int ADDRESS_BITS = 17;
  localparam int ROW_BITS = 11;
  localparam int COL_BITS = 11;
  localparam int DATA_BITS = 12;
  typedef enum logic [4:0] {
    IDLE     = 5'b00001,
    LOAD     = 5'b00010,
    SYNC     = 5'b00100,
    KICK     = 5'b01000,
    WAIT_CFA = 5'b10000
  } loader_state_t;
  typedef enum logic [1:0] {
    CFA_IDLE    = 2'd0,
    GREEN_INTRP = 2'd1,
    RB_INTRP    = 2'd2
  } cfa_phase_t;
  typedef enum logic [1:0] {
    BAYER_R  = 2'd0,
    BAYER_GR = 2'd1,
    BAYER_GB = 2'd2,
    BAYER_B  = 2'd3
  } bayer_t;
  function automatic logic accepts_pixels(loader_state_t s);
    return s inside {IDLE, LOAD, SYNC};
  endfunction
endpackage

// File: rtl/raw_position_tracker.sv
// raw_position_tracker: raster row/col/address counters checked against the maxima latched at frame start
module raw_position_tracker
  import cfa_pkg::*;
#(
  parameter int addressBitWidth = ADDRESS_BITS,
  parameter int rowBitWidth = ROW_BITS,
  parameter int colBitWidth = COL_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       advance,
  input  logic                       restart,
  input  logic                       eol,
  input  logic [rowBitWidth-1:0]     rowMax,
  input  logic [colBitWidth-1:0]     colMax,
  output logic [rowBitWidth-1:0]     row,
  output logic [colBitWidth-1:0]     col,
  output logic [addressBitWidth-1:0] address,
  output logic                       lastPixel,
  output logic                       eolMismatch
);
  logic [rowBitWidth-1:0] row_q, row_max_q, row_max;
  logic [colBitWidth-1:0] col_q, col_max_q, col_max;
  logic [addressBitWidth-1:0] address_q;
  logic col_end;
  // a restarting pixel is judged at (0,0) against the maxima arriving with it
  assign row = restart ? '0 : row_q;
  assign col = restart ? '0 : col_q;
  assign address = restart ? '0 : address_q;
  assign row_max = restart ? rowMax : row_max_q;
  assign col_max = restart ? colMax : col_max_q;
  assign col_end = col == col_max;
  assign eolMismatch = eol != col_end;
  assign lastPixel = eol & col_end & (row == row_max);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
      address_q <= '0;
      row_max_q <= '0;
      col_max_q <= '0;
    end else begin
      if (restart) begin
        row_max_q <= rowMax;
        col_max_q <= colMax;
      end
      if (advance) begin
        address_q <= address + 1'b1;
        col_q <= eol ? '0 : col + 1'b1;
        row_q <= eol ? row + 1'b1 : row;
      end
    end
endmodule

// File: rtl/raw_frame_loader.sv
// raw_frame_loader: framing-checked raw pixel ingest into frame memory, then launches CFA_2 and waits for done
module raw_frame_loader
  import cfa_pkg::*;
#(
  parameter int addressBitWidth = ADDRESS_BITS,
  parameter int rowBitWidth = ROW_BITS,
  parameter int colBitWidth = COL_BITS,
  parameter int dataBitWidth = DATA_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [rowBitWidth-1:0]     rowMax,
  input  logic [colBitWidth-1:0]     colMax,
  input  logic [dataBitWidth-1:0]    pixIn,
  input  logic                       pixValid,
  input  logic                       sof,
  input  logic                       eol,
  output logic                       pixReady,
  output logic [addressBitWidth-1:0] rawWriteAddress,
  output logic [dataBitWidth-1:0]    rawWriteData,
  output logic                       rawWriteEnable,
  output logic                       cfaStart,
  input  logic                       cfaDone,
  output logic                       busy,
  output logic                       lineError,
  output logic [7:0]                 frameCount
);
  loader_state_t state, next;
  logic [rowBitWidth-1:0] row;
  logic [colBitWidth-1:0] col;
  logic [addressBitWidth-1:0] address;
  logic last_pixel, mismatch, take, restart, advance, ready_next, kick;
  logic unused_position;
  // outside LOAD only a frame start is taken; everything else is dropped
  assign take = pixValid & pixReady & (sof | (state == LOAD));
  assign restart = take & sof;
  assign advance = take & ~mismatch;
  assign unused_position = ^{row, col};
  raw_position_tracker #(
    .addressBitWidth(addressBitWidth),
    .rowBitWidth(rowBitWidth),
    .colBitWidth(colBitWidth)
  ) u_tracker (
    .clk(clk),
    .rst(rst),
    .advance(advance),
    .restart(restart),
    .eol(eol),
    .rowMax(rowMax),
    .colMax(colMax),
    .row(row),
    .col(col),
    .address(address),
    .lastPixel(last_pixel),
    .eolMismatch(mismatch)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    if (take) next = mismatch ? SYNC : last_pixel ? KICK : LOAD;
    else if (state == KICK) next = WAIT_CFA;
    else if ((state == WAIT_CFA) && cfaDone) next = IDLE;
  end
  always_comb begin
    ready_next = accepts_pixels(next);
    kick = state == KICK;
    busy = state inside {LOAD, KICK, WAIT_CFA};
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pixReady <= 1'b0;
      rawWriteEnable <= 1'b0;
      rawWriteAddress <= '0;
      rawWriteData <= '0;
      cfaStart <= 1'b0;
      frameCount <= '0;
      lineError <= 1'b0;
    end else begin
      pixReady <= ready_next;
      rawWriteEnable <= advance;
      if (advance) begin
        rawWriteAddress <= address;
        rawWriteData <= pixIn;
      end
      cfaStart <= kick;
      frameCount <= frameCount + {7'd0, kick};
      // a completed frame clears the error; a restart or resync mid-frame keeps it raised
      if (take) lineError <= ~last_pixel & (mismatch | ((state != IDLE) & (sof | lineError)));
    end
endmodule
